// File: rtl/ictrl_ibuffer_fetch.sv
// ictrl_ibuffer_fetch
//
// Instruction fetch stage that reads ibuffer lines once a program has been
// loaded, splits each line into INST_WIDTH instructions (lane 0 in the LSBs)
// and hands them to the decoder over a valid/ready handshake. Fetching starts
// at a given PC, may be bounded by an instruction count (0 = unlimited), and
// can be redirected by a jump or aborted by a stop.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   load_done           - pulse: program fully written to ibuffer
//   fetch_start         - pulse: begin fetching (honoured only when loaded)
//   fetch_start_pc      - first instruction PC, sampled with fetch_start
//   fetch_inst_num      - instructions to deliver, 0 = unlimited
//   fetch_stop          - abort, sampled every cycle
//   jump_valid, jump_pc - redirect request and target
//   fetch_busy          - fetch in progress
//   fetch_done          - pulse with the final instruction handshake
//   ibuffer_rd_*        - line read request / 1-cycle-latency response
//   inst_valid/ready    - decoder handshake
//   inst_data, inst_pc  - instruction and its PC (instruction units)

module ictrl_ibuffer_fetch #(
    parameter  int DATA_WIDTH = 128,
    parameter  int MEM_AW     = 15,
    parameter  int INST_WIDTH = 32,
    localparam int OFS_W      = $clog2(DATA_WIDTH / INST_WIDTH),
    localparam int PC_W       = MEM_AW + OFS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_done,
    input  logic                  fetch_start,
    input  logic [PC_W-1:0]       fetch_start_pc,
    input  logic [PC_W-1:0]       fetch_inst_num,
    input  logic                  fetch_stop,
    input  logic                  jump_valid,
    input  logic [PC_W-1:0]       jump_pc,
    output logic                  fetch_busy,
    output logic                  fetch_done,
    output logic                  ibuffer_rd_cen,
    input  logic                  ibuffer_rd_ready,
    output logic [MEM_AW-1:0]     ibuffer_rd_addr,
    input  logic                  ibuffer_rd_rvalid,
    input  logic [DATA_WIDTH-1:0] ibuffer_rd_rdata,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [PC_W-1:0]       inst_pc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RD,
        S_DELIVER
    } state_t;

    state_t                state;
    logic                  loaded;
    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       cnt;
    logic [PC_W-1:0]       num;
    logic [DATA_WIDTH-1:0] line;

    logic [OFS_W-1:0]      ofs;
    logic [PC_W-1:0]       cnt_nxt;
    logic [PC_W-1:0]       pc_nxt;
    logic                  start_ok;
    logic                  hs;
    logic                  last;

    assign ofs     = pc[OFS_W-1:0];
    assign cnt_nxt = cnt + PC_W'(1);
    assign pc_nxt  = pc + PC_W'(1);

    // A load_done in the same cycle as fetch_start counts as loaded.
    assign start_ok = (state == S_IDLE) && fetch_start && (loaded || load_done);

    assign hs   = inst_valid && inst_ready;
    assign last = hs && (num != '0) && (cnt_nxt == num);

    // Outputs are decodes of registered state/pc/line; only the request
    // gating and the done pulse see current-cycle inputs.
    assign fetch_busy      = (state != S_IDLE);
    assign inst_valid      = (state == S_DELIVER);
    assign ibuffer_rd_cen  = (state == S_REQ) && !jump_valid && !fetch_stop;
    assign fetch_done      = last && !fetch_stop;
    assign ibuffer_rd_addr = pc[PC_W-1:OFS_W];
    assign inst_data       = line[ofs*INST_WIDTH +: INST_WIDTH];
    assign inst_pc         = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            loaded <= 1'b0;
            pc     <= '0;
            cnt    <= '0;
            num    <= '0;
            line   <= '0;
        end else begin
            if (load_done) begin
                loaded <= 1'b1;
            end

            if (state == S_IDLE) begin
                if (start_ok) begin
                    pc    <= fetch_start_pc;
                    num   <= fetch_inst_num;
                    cnt   <= '0;
                    state <= S_REQ;
                end
            end else if (fetch_stop) begin
                // Abort: an instruction accepted this cycle is still consumed.
                if (hs) begin
                    cnt <= cnt_nxt;
                    pc  <= pc_nxt;
                end
                state <= S_IDLE;
            end else if (jump_valid) begin
                // Redirect discards the in-flight/buffered line; a coinciding
                // final handshake still completes the run.
                if (hs) begin
                    cnt <= cnt_nxt;
                end
                if (last) begin
                    pc    <= pc_nxt;
                    state <= S_IDLE;
                end else begin
                    pc    <= jump_pc;
                    state <= S_REQ;
                end
            end else begin
                case (state)
                    S_REQ: begin
                        if (ibuffer_rd_cen && ibuffer_rd_ready) begin
                            state <= S_WAIT_RD;
                        end
                    end
                    S_WAIT_RD: begin
                        // Missing rvalid is a protocol error; hold here.
                        if (ibuffer_rd_rvalid) begin
                            line  <= ibuffer_rd_rdata;
                            state <= S_DELIVER;
                        end
                    end
                    S_DELIVER: begin
                        if (hs) begin
                            pc  <= pc_nxt;
                            cnt <= cnt_nxt;
                            if (last) begin
                                state <= S_IDLE;
                            end else if (&ofs) begin
                                state <= S_REQ;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
